core_mem_port: RTL and testbench

- Per-core request adapter that sits directly upstream of the 4-core shared-RAM arbiter. One instance exists per core.
- Accepts single load/store requests from a core over a valid/ready handshake and drives that core's rden/wren bit and its byte lanes of the arbiter's Address/Din buses.
- Waits for the arbiter's grant (acq), counts the fixed RAM latency, then captures the core's byte of Dq.
- Returns exactly one response per request, with a timeout error if the grant never arrives.

---
 rtl/core_mem_port.sv | 178 +++++++++++++++++
 tb/tb_core_mem_port.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_port.sv
// Per-core request adapter in front of the 4-core shared-RAM arbiter: takes one
// load/store at a time, waits for grant, counts RAM latency and returns one response.
module core_mem_port #(
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       mem_rden,
  output logic       mem_wren,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic       mem_acq,
  input  logic [7:0] mem_dq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    LAT  = 3'd2,
    RESP = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
  localparam bit          NO_GAP   = (GAP_CYC == 0);

  state_t      state_r;
  state_t      state_s;
  logic        we_r;
  logic [7:0]  addr_r;
  logic [7:0]  wdata_r;
  logic [7:0]  data_r;
  logic        err_r;
  logic [15:0] wait_r;
  logic [2:0]  lat_r;
  logic [7:0]  gap_r;

  logic        accept_s;
  logic        timeout_s;
  logic        lat_done_s;
  logic [15:0] wait_inc_s;
  logic        nxt_we_s;
  logic [7:0]  nxt_addr_s;
  logic [7:0]  nxt_wdata_s;
  logic        nxt_busy_s;

  // Next-state decode; a grant in the same cycle as the timeout takes priority.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    timeout_s   = 1'b0;
    lat_done_s  = 1'b0;
    wait_inc_s  = (wait_r == 16'hFFFF) ? wait_r : (wait_r + 16'd1);
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = ARB;
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        if (mem_acq) begin
          state_s = LAT;
        end else if ((TO_LIMIT != 16'd0) && (wait_inc_s == TO_LIMIT)) begin
          timeout_s = 1'b1;
          state_s   = RESP;
        end else begin
          state_s = ARB;
        end
      end
      LAT: begin
        if (lat_r == LAT_LAST) begin
          lat_done_s = 1'b1;
          state_s    = RESP;
        end else begin
          state_s = LAT;
        end
      end
      RESP: begin
        if (NO_GAP) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: state_s = IDLE;
    endcase
    nxt_we_s    = accept_s ? req_we    : we_r;
    nxt_addr_s  = accept_s ? req_addr  : addr_r;
    nxt_wdata_s = accept_s ? req_wdata : wdata_r;
    nxt_busy_s  = (state_s == ARB) || (state_s == LAT);
  end

  // State, request latches and the wait/latency/gap counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      addr_r  <= 8'd0;
      wdata_r <= 8'd0;
      data_r  <= 8'd0;
      err_r   <= 1'b0;
      wait_r  <= 16'd0;
      lat_r   <= 3'd0;
      gap_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        data_r  <= 8'd0;
        err_r   <= 1'b0;
        wait_r  <= 16'd0;
      end else if (state_r == ARB) begin
        wait_r <= wait_inc_s;
        err_r  <= timeout_s;
      end else if (lat_done_s && !we_r) begin
        data_r <= mem_dq;
      end
      if ((state_r == ARB) && mem_acq) begin
        lat_r <= 3'd1;
      end else if ((state_r == LAT) && !lat_done_s) begin
        lat_r <= lat_r + 3'd1;
      end
      if (state_r == RESP) begin
        gap_r <= 8'd0;
      end else if (state_r == GAP) begin
        gap_r <= gap_r + 8'd1;
      end
    end
  end

  // Registered port outputs; the arbiter side tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b1;
      mem_rden   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= 8'd0;
      mem_din    <= 8'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 8'd0;
      resp_err   <= 1'b0;
    end else begin
      req_ready  <= (state_s == IDLE);
      mem_rden   <= nxt_busy_s && !nxt_we_s;
      mem_wren   <= nxt_busy_s && nxt_we_s;
      mem_addr   <= (state_s != IDLE) ? nxt_addr_s  : 8'd0;
      mem_din    <= (state_s != IDLE) ? nxt_wdata_s : 8'd0;
      resp_valid <= (state_r == RESP);
      resp_rdata <= (state_r == RESP) ? data_r : 8'd0;
      resp_err   <= (state_r == RESP) && err_r;
    end
  end

endmodule

// File: tb/tb_core_mem_port.sv
// Bench: four adapters behind a behavioural priority arbiter and RAM, plus a fifth
// adapter (TIMEOUT=8) whose grant never arrives.
module tb_core_mem_port;

  localparam int RD_LAT  = 2;
  localparam int GAP_CYC = 2;
  localparam int TO_SHORT = 8;

  logic clk;
  logic rst;
  logic       rv   [5];
  logic       rr   [5];
  logic       rwe  [5];
  logic [7:0] ra   [5];
  logic [7:0] rwd  [5];
  logic       pv   [5];
  logic [7:0] prd  [5];
  logic       perr [5];
  logic       rden [5];
  logic       wren [5];
  logic [7:0] maddr[5];
  logic [7:0] mdin [5];
  logic       acq  [5];
  logic [7:0] dq   [5];
  logic       force_acq[4];

  logic [7:0] ram [256];
  logic [7:0] model_mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;
  int owner_r = -1;
  int pick_s;
  int grant_cnt[5] = '{default: 0};
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_core
    core_mem_port #(.RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC), .TIMEOUT(64)) u_dut (
      .clk(clk), .rst(rst), .req_valid(rv[g]), .req_ready(rr[g]), .req_we(rwe[g]),
      .req_addr(ra[g]), .req_wdata(rwd[g]), .resp_valid(pv[g]), .resp_rdata(prd[g]),
      .resp_err(perr[g]), .mem_rden(rden[g]), .mem_wren(wren[g]), .mem_addr(maddr[g]),
      .mem_din(mdin[g]), .mem_acq(acq[g]), .mem_dq(dq[g]));
  end

  core_mem_port #(.RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC), .TIMEOUT(TO_SHORT)) u_to (
    .clk(clk), .rst(rst), .req_valid(rv[4]), .req_ready(rr[4]), .req_we(rwe[4]),
    .req_addr(ra[4]), .req_wdata(rwd[4]), .resp_valid(pv[4]), .resp_rdata(prd[4]),
    .resp_err(perr[4]), .mem_rden(rden[4]), .mem_wren(wren[4]), .mem_addr(maddr[4]),
    .mem_din(mdin[4]), .mem_acq(acq[4]), .mem_dq(dq[4]));

  for (genvar g = 0; g < 5; g++) begin : g_dq
    assign dq[g] = ram[maddr[g]];
  end

  // Fixed-priority arbiter: a holder keeps the grant while it requests, else lowest index wins.
  always_comb begin
    pick_s = -1;
    if (owner_r >= 0 && (rden[owner_r] || wren[owner_r])) begin
      pick_s = owner_r;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (rden[i] || wren[i]) pick_s = i;
      end
    end
    for (int i = 0; i < 4; i++) acq[i] = (pick_s == i) || force_acq[i];
    acq[4] = 1'b0;
  end

  always @(posedge clk) begin
    owner_r <= pick_s;
    cyc <= cyc + 1;
    if (pre_we) ram[pre_addr] <= pre_data;
    for (int i = 0; i < 4; i++) begin
      if (acq[i] && wren[i]) ram[maddr[i]] <= mdin[i];
    end
    for (int i = 0; i < 5; i++) begin
      if (acq[i] && (rden[i] || wren[i])) grant_cnt[i] <= grant_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on core c; exp_lat < 0 skips the latency check.
  task automatic do_txn(input int c, input logic we, input logic [7:0] a, input logic [7:0] d,
                        input int exp_lat, input logic exp_err, output int resp_at);
    int n;
    int lat;
    int k;
    int g0;
    logic [7:0] exp_rd;
    n = 0;
    while (rr[c] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(rr[c]), 32'd1);
    rv[c] = 1'b1; rwe[c] = we; ra[c] = a; rwd[c] = d;
    @(posedge clk);
    g0 = grant_cnt[c];
    exp_rd = (we || exp_err) ? 8'd0 : model_mem[a];
    #1 rv[c] = 1'b0;
    chk("arb_rden", 32'(rden[c]), 32'(!we));
    chk("arb_wren", 32'(wren[c]), 32'(we));
    chk("arb_addr", 32'(maddr[c]), 32'(a));
    chk("arb_din",  32'(mdin[c]), 32'(d));
    chk("busy_not_ready", 32'(rr[c]), 32'd0);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (pv[c] !== 1'b1 && lat < 300);
    chk("resp_seen", 32'(pv[c]), 32'd1);
    if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_rdata", 32'(prd[c]), 32'(exp_rd));
    chk("resp_err", 32'(perr[c]), 32'(exp_err));
    chk("strobes_low_at_resp", 32'(rden[c] | wren[c]), 32'd0);
    if (c < 4) chk("grant_before_resp", 32'(grant_cnt[c] > g0), 32'd1);
    if (we && !exp_err) model_mem[a] = d;
    resp_at = cyc;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (k == 1) chk("resp_one_cycle", 32'(pv[c]), 32'd0);
    end while (rr[c] !== 1'b1 && k < 50);
    chk("gap_cycles", 32'(k), 32'(GAP_CYC));
    @(negedge clk);
  endtask

  initial begin
    int t0;
    int t2;
    int dummy;
    logic [7:0] a;
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = 8'd0; pre_data = 8'd0;
    for (int i = 0; i < 5; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; ra[i] = 8'd0; rwd[i] = 8'd0;
    end
    for (int i = 0; i < 4; i++) force_acq[i] = 1'b0;

    // Preload RAM (and the model) while held in reset.
    pre_we = 1'b1;
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      pre_addr = (i == 256) ? 8'h12 : 8'(i);
      pre_data = (i == 256) ? 8'hA5 : 8'($urandom);
      model_mem[pre_addr] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_ready", 32'(rr[i]), 32'd1);
      chk("rst_rden",  32'(rden[i]), 32'd0);
      chk("rst_wren",  32'(wren[i]), 32'd0);
      chk("rst_addr",  32'(maddr[i]), 32'd0);
      chk("rst_resp",  32'(pv[i]), 32'd0);
      chk("rst_rdata", 32'(prd[i]), 32'd0);
      chk("rst_err",   32'(perr[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    do_txn(0, 1'b0, 8'h12, 8'h00, 1 + 1 + RD_LAT, 1'b0, dummy);
    do_txn(0, 1'b1, 8'h40, 8'h3C, 1 + 1 + RD_LAT, 1'b0, dummy);
    do_txn(0, 1'b0, 8'h40, 8'h00, 1 + 1 + RD_LAT, 1'b0, dummy);
    chk("readback_model", 32'(model_mem[8'h40]), 32'h3C);

    for (int i = 0; i < 24; i++) begin
      do_txn($urandom_range(0, 3), 1'($urandom), 8'($urandom), 8'($urandom),
             1 + 1 + RD_LAT, 1'b0, dummy);
    end

    // Contention: core 0 wins, core 2 keeps its rden up while waiting.
    fork
      do_txn(0, 1'b0, 8'h12, 8'h00, 1 + 1 + RD_LAT, 1'b0, t0);
      do_txn(2, 1'b0, 8'h40, 8'h00, -1, 1'b0, t2);
      begin
        @(posedge clk);
        repeat (3) begin
          @(posedge clk); #1;
          chk("core2_rden_held", 32'(rden[2]), 32'd1);
        end
      end
    join
    chk("core0_first", 32'(t0 < t2), 32'd1);

    do_txn(4, 1'b0, 8'h55, 8'h00, TO_SHORT + 1, 1'b1, dummy);

    // Reset during LAT drops the strobes with no response.
    a = 8'h21;
    rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = a;
    @(posedge clk); #1 rv[1] = 1'b0;
    @(posedge clk); #1;
    chk("midlat_rden", 32'(rden[1]), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_drop_rden", 32'(rden[1]), 32'd0);
    chk("rst_drop_wren", 32'(wren[1]), 32'd0);
    chk("rst_no_resp", 32'(pv[1]), 32'd0);
    chk("rst_ready_again", 32'(rr[1]), 32'd1);
    @(negedge clk) rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("no_resp_after_rst", 32'(pv[1]), 32'd0);
    end
    @(negedge clk);
    do_txn(1, 1'b0, a, 8'h00, 1 + 1 + RD_LAT, 1'b0, dummy);

    // Stale acq during GAP/IDLE must not advance anything.
    force_acq[0] = 1'b1;
    do_txn(0, 1'b1, 8'h77, 8'h9E, 1 + 1 + RD_LAT, 1'b0, dummy);
    repeat (4) begin
      @(posedge clk); #1;
      chk("stale_idle_ready", 32'(rr[0]), 32'd1);
      chk("stale_idle_rden", 32'(rden[0] | wren[0]), 32'd0);
      chk("stale_idle_resp", 32'(pv[0]), 32'd0);
    end
    @(negedge clk);
    do_txn(0, 1'b0, 8'h77, 8'h00, 1 + 1 + RD_LAT, 1'b0, dummy);
    force_acq[0] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
